// File: rtl/asic_output_analyzer_if.sv
// Sample stream into the output analyzer and the classification results out of it.
//   master : sample source / result consumer (drives sample_*, reads results)
//   slave  : the analyzer (reads sample_*, drives avg_aux*, network_output,
//            output_valid, result_strobe)
interface asic_output_analyzer_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  sample_valid;
    logic [1:0]            sample_chan;
    logic [DATA_WIDTH-1:0] sample_data;

    logic [DATA_WIDTH-1:0] avg_aux0;
    logic [DATA_WIDTH-1:0] avg_aux1;
    logic [DATA_WIDTH-1:0] avg_aux2;
    logic [DATA_WIDTH-1:0] avg_aux3;
    logic [1:0]            network_output;
    logic                  output_valid;
    logic                  result_strobe;

    modport master (
        output sample_valid, sample_chan, sample_data,
        input  avg_aux0, avg_aux1, avg_aux2, avg_aux3,
        input  network_output, output_valid, result_strobe
    );

    modport slave (
        input  sample_valid, sample_chan, sample_data,
        output avg_aux0, avg_aux1, avg_aux2, avg_aux3,
        output network_output, output_valid, result_strobe
    );
endinterface

// File: rtl/asic_output_analyzer.sv
// Averages the four ASIC output-neuron voltages (AUX0..AUX3) over fixed
// windows of 2^AVG_LOG2 samples per channel, picks the winning neuron with
// threshold and hysteresis, and presents a registered classification.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave side of asic_output_analyzer_if
//          in : sample_valid, sample_chan[1:0], sample_data[DATA_WIDTH-1:0]
//          out: avg_aux0..3, network_output[1:0], output_valid, result_strobe
module asic_output_analyzer #(
    parameter int unsigned           AVG_LOG2   = 4,
    parameter int unsigned           DATA_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0] THRESHOLD  = DATA_WIDTH'(12'h200),
    parameter logic [DATA_WIDTH-1:0] HYST       = DATA_WIDTH'(12'h020)
) (
    input  logic                    clk,
    input  logic                    rst,
    asic_output_analyzer_if.slave   bus
);
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned AW     = DATA_WIDTH + AVG_LOG2;
    localparam int unsigned CW     = AVG_LOG2 + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(2 ** AVG_LOG2);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPARE = 2'd1,
        DECIDE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         acc_q  [NUM_CH];
    logic [AW-1:0]         acc_d  [NUM_CH];
    logic [CW-1:0]         cnt_q  [NUM_CH];
    logic [CW-1:0]         cnt_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] avg_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] avg_d  [NUM_CH];
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] best_q, best_d;
    logic [1:0]            best_idx_q, best_idx_d;
    logic [1:0]            net_q, net_d;
    logic                  valid_q, valid_d;
    logic                  strobe_q, strobe_d;

    // Accumulator values including this cycle's sample (if it fits)
    logic [AW-1:0]         acc_n  [NUM_CH];
    logic [CW-1:0]         cnt_n  [NUM_CH];
    logic                  all_full;
    logic [DATA_WIDTH:0]   hyst_limit;

    // Next-state, accumulation, compare scan and decision
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        net_d      = net_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        all_full   = 1'b1;
        hyst_limit = {1'b0, avg_q[net_q]} + {1'b0, HYST};

        for (int i = 0; i < NUM_CH; i++) begin
            acc_n[i] = acc_q[i];
            cnt_n[i] = cnt_q[i];
            // Samples on a full channel are dropped; the accumulator is sized
            // so a full window can never wrap.
            if (bus.sample_valid && (bus.sample_chan == 2'(i)) && (cnt_q[i] < CNT_FULL)) begin
                acc_n[i] = acc_q[i] + AW'(bus.sample_data);
                cnt_n[i] = cnt_q[i] + CW'(1);
            end
            if (cnt_n[i] != CNT_FULL) begin
                all_full = 1'b0;
            end
            acc_d[i] = acc_n[i];
            cnt_d[i] = cnt_n[i];
            avg_d[i] = avg_q[i];
        end

        case (state_q)
            ACCUM: begin
                // Completion includes the sample arriving this cycle, so the
                // completing sample edge is the edge that latches the averages.
                if (all_full) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        avg_d[i] = DATA_WIDTH'(acc_n[i] >> AVG_LOG2);
                        acc_d[i] = '0;
                        cnt_d[i] = '0;
                        // A sample not consumed above (its channel was already
                        // saturated) starts the new window.
                        if (bus.sample_valid && (bus.sample_chan == 2'(i)) && (cnt_q[i] == CNT_FULL)) begin
                            acc_d[i] = AW'(bus.sample_data);
                            cnt_d[i] = CW'(1);
                        end
                    end
                    idx_d      = 2'd0;
                    best_d     = '0;
                    best_idx_d = 2'd0;
                    state_d    = COMPARE;
                end
            end

            COMPARE: begin
                // Strictly greater: ties keep the lowest index
                if (avg_q[idx_q] > best_q) begin
                    best_d     = avg_q[idx_q];
                    best_idx_d = idx_q;
                end
                idx_d = 2'(idx_q + 2'd1);
                if (idx_q == 2'd3) begin
                    state_d = DECIDE;
                end
            end

            DECIDE: begin
                strobe_d = 1'b1;
                state_d  = ACCUM;
                if (best_q < THRESHOLD) begin
                    valid_d = 1'b0;
                end else if (valid_q && (best_idx_q != net_q) &&
                             ({1'b0, best_q} <= hyst_limit)) begin
                    // Challenger not clearly ahead of the current winner
                    valid_d = 1'b1;
                end else begin
                    net_d   = best_idx_q;
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            idx_q      <= 2'd0;
            best_q     <= '0;
            best_idx_q <= 2'd0;
            net_q      <= 2'd0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                avg_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            net_q      <= net_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
                avg_q[i] <= avg_d[i];
            end
        end
    end

    assign bus.avg_aux0       = avg_q[0];
    assign bus.avg_aux1       = avg_q[1];
    assign bus.avg_aux2       = avg_q[2];
    assign bus.avg_aux3       = avg_q[3];
    assign bus.network_output = net_q;
    assign bus.output_valid   = valid_q;
    assign bus.result_strobe  = strobe_q;

endmodule
